taxi_axis_frame_fifo: RTL and testbench
=======================================

// Module: taxi_axis_frame_fifo
// PURPOSE
//  Single-clock AXI-stream FIFO for the MAC TX path, between the application source and the 64-bit XGMII MAC.
//  Generalises the fixed 64-bit stream bundle: data width, depth and tuser width are parameters.
//  Adds optional store-and-forward frame mode, bad-frame dropping and drop-on-full.
//  Exports occupancy and per-frame status pulses.
// PARAMETERS
//  DATA_W          64              stream data width, bits (multiple of 8)
//  KEEP_W          DATA_W/8        tkeep width; one bit per byte
//  USER_W          2               tuser width; tuser[0] = bad-frame flag on the tlast beat
//  DEPTH           512             storage depth in words; power of 2, >= 4
//  FRAME_FIFO      1'b1            1: release a frame only after its tlast is stored; 0: word-cut-through
//  DROP_BAD_FRAME  1'b1            FRAME_FIFO only: discard a frame whose tlast beat has tuser[0]=1
//  DROP_WHEN_FULL  1'b0            FRAME_FIFO only: s_axis_tready held 1; frame that hits full is discarded
// PORTS
//  tx_clk             in   1           clock
//  tx_rst             in   1           asynchronous reset, active-high
//  s_axis_tdata       in   DATA_W      input data
//  s_axis_tkeep       in   KEEP_W      input byte enables
//  s_axis_tuser       in   USER_W      input sideband
//  s_axis_tlast       in   1           input end of frame
//  s_axis_tvalid      in   1           input valid
//  s_axis_tready      out  1           input ready
//  m_axis_tdata/tkeep/tuser/tlast  out  DATA_W/KEEP_W/USER_W/1  output stream, registered
//  m_axis_tvalid      out  1           output valid
//  m_axis_tready      in   1           output ready
//  status_depth       out  ADDR_W+1    words in RAM (wr_ptr_cur - rd_ptr), ADDR_W=$clog2(DEPTH)
//  status_overflow    out  1           1-cycle pulse: frame discarded due to full
//  status_bad_frame   out  1           1-cycle pulse: frame discarded due to tuser[0]
//  status_good_frame  out  1           1-cycle pulse: frame committed
// BEHAVIOUR
//  Reset (tx_rst=1, async): all pointers 0, write FSM=IDLE, m_axis_tvalid=0, s_axis_tready=0, status pulses 0, status_depth=0.
//  Pointers are ADDR_W+1 bits and wrap mod 2*DEPTH.
//  empty = (rd_ptr == wr_ptr_commit). full = (wr_ptr_cur - rd_ptr == DEPTH).
//  Transfer occurs on valid&ready only. Input beat data/tkeep/tuser/tlast is stored as one word.
//  FRAME_FIFO=0: wr_ptr_commit tracks wr_ptr_cur each write.
//  FRAME_FIFO=0 latency: beat accepted on cycle N into an empty FIFO appears on m_axis at N+1 (RAM bypass-free, registered read).
//  FRAME_FIFO=1: wr_ptr_commit <= wr_ptr_cur+1 on the accepted tlast beat of a good frame; the frame becomes readable 1 cycle later.
//  Write FSM: IDLE -(accepted beat, no tlast)-> WRITE. WRITE -(accepted tlast)-> IDLE. {IDLE,WRITE} -(full condition below)-> DROP. DROP -(accepted tlast)-> IDLE.
//  Single-beat frame (tlast on first beat): IDLE->IDLE with commit.
//  Bad frame (DROP_BAD_FRAME=1, tuser[0]=1 on tlast): wr_ptr_cur <= wr_ptr_commit; status_bad_frame=1 next cycle.
//  Full handling, DROP_WHEN_FULL=0: s_axis_tready = !full.
//  Full handling, DROP_WHEN_FULL=1: s_axis_tready = 1; beat arriving while full -> DROP, wr_ptr_cur rewound, status_overflow pulses on the tlast.
//  Oversize frame (FRAME_FIFO=1, full with wr_ptr_commit==rd_ptr): enter DROP regardless of DROP_WHEN_FULL (no deadlock), same rewind and pulse.
//  In DROP: all beats accepted and discarded until tlast.
//  Simultaneous read and write when full: tready follows full of the current cycle; no same-cycle pass-through.
//  Read side: output register loads when (!m_axis_tvalid | m_axis_tready) & !empty; rd_ptr increments on load.
//  m_axis_tvalid drops only when the register empties with FIFO empty.
//  Output stable while m_axis_tvalid=1 and m_axis_tready=0.
//  status_good_frame pulses 1 cycle after commit (FRAME_FIFO=1); in FRAME_FIFO=0 it pulses on every accepted tlast.
//  Status pulses are mutually exclusive per frame.
// TESTING
//  Reset, then 1 beat tdata=64'h0123_4567_89AB_CDEF, tkeep=8'hFF, tlast=1, FRAME_FIFO=0 -> m_axis_tvalid=1 next cycle, same data; good_frame pulse.
//  FRAME_FIFO=1, 4-beat frame with m_axis_tready=1 -> m_axis_tvalid stays 0 until the cycle after beat 4 accepted; then 4 beats back-to-back, tlast on 4th, tkeep=8'h0F kept.
//  FRAME_FIFO=1, 3-beat frame, tuser[0]=1 on tlast -> nothing output, status_bad_frame=1 one cycle, status_depth returns to 0.
//  DEPTH=4, DROP_WHEN_FULL=0, m_axis_tready=0, stream 6 beats -> s_axis_tready=0 after 4 words; status_depth=4; stalled output data unchanged.
//  DEPTH=4, FRAME_FIFO=1, 6-beat frame -> frame dropped, status_overflow=1 once, next 2-beat frame passes intact.
//  Assert tx_rst mid-frame with m_axis_tvalid=1 -> m_axis_tvalid=0 and status_depth=0 immediately; next frame after release passes normally.

Source files
------------

// File: rtl/taxi_axis_frame_fifo_if.sv
// ---------------------------------------------------------------------------
// taxi_axis_frame_fifo_if
//   AXI-stream bundle used on both sides of taxi_axis_frame_fifo.
//   Widths are parameters so the same bundle covers any data/keep/user size.
//   master : drives tdata/tkeep/tuser/tlast/tvalid, samples tready
//   slave  : samples tdata/tkeep/tuser/tlast/tvalid, drives tready
// ---------------------------------------------------------------------------
interface taxi_axis_frame_fifo_if #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W / 8,
  parameter int USER_W = 2
);
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic [USER_W-1:0] tuser;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tkeep, output tuser, output tlast,
                  output tvalid, input tready);
  modport slave  (input tdata, input tkeep, input tuser, input tlast,
                  input tvalid, output tready);
endinterface

// File: rtl/taxi_axis_frame_fifo.sv
// ---------------------------------------------------------------------------
// taxi_axis_frame_fifo
//   Single-clock AXI-stream FIFO sitting between the application source and
//   the XGMII MAC transmit path. Optional store-and-forward frame mode with
//   bad-frame dropping and drop-on-full.
//
// Ports
//   tx_clk, tx_rst      clock, asynchronous active-high reset
//   s_axis (slave)      input stream  (tdata/tkeep/tuser/tlast/tvalid/tready)
//   m_axis (master)     output stream, registered
//   status_depth        words held in RAM (uncommitted ones included)
//   status_overflow     1-cycle pulse: frame discarded because of full
//   status_bad_frame    1-cycle pulse: frame discarded because tuser[0]=1
//   status_good_frame   1-cycle pulse: frame committed
// ---------------------------------------------------------------------------
module taxi_axis_frame_fifo #(
  parameter int DATA_W         = 64,
  parameter int KEEP_W         = DATA_W / 8,
  parameter int USER_W         = 2,
  parameter int DEPTH          = 512,
  parameter bit FRAME_FIFO     = 1'b1,
  parameter bit DROP_BAD_FRAME = 1'b1,
  parameter bit DROP_WHEN_FULL = 1'b0
) (
  input  logic                    tx_clk,
  input  logic                    tx_rst,
  taxi_axis_frame_fifo_if.slave   s_axis,
  taxi_axis_frame_fifo_if.master  m_axis,
  output logic [$clog2(DEPTH):0]  status_depth,
  output logic                    status_overflow,
  output logic                    status_bad_frame,
  output logic                    status_good_frame
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int WORD_W = DATA_W + KEEP_W + USER_W + 1;

  typedef logic [ADDR_W:0] ptr_t;
  localparam ptr_t FULL_CNT = ptr_t'(DEPTH);
  localparam ptr_t PTR_ONE  = ptr_t'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_DROP
  } wr_state_t;

  logic [WORD_W-1:0] mem_q [DEPTH];

  ptr_t      wr_ptr_cur_q;
  ptr_t      wr_ptr_commit_q;
  ptr_t      rd_ptr_q;
  wr_state_t wr_state_q;
  logic      overflow_q;
  logic      bad_frame_q;
  logic      good_frame_q;

  logic              m_tvalid_q;
  logic [WORD_W-1:0] m_word_q;

  logic              full;
  logic              empty;
  logic              hit_full;
  logic              s_ready;
  logic              s_accept;
  logic              drop_beat;
  logic              mem_we;
  logic              m_load;
  logic [WORD_W-1:0] in_word;

  assign full  = (wr_ptr_cur_q - rd_ptr_q) == FULL_CNT;
  assign empty = (rd_ptr_q == wr_ptr_commit_q);

  // A frame that fills the whole RAM on its own can never be committed, so it
  // is dropped even without DROP_WHEN_FULL; otherwise the input would stall
  // forever waiting for space that only its own tlast could free.
  assign hit_full = FRAME_FIFO && full &&
                    (DROP_WHEN_FULL || (wr_ptr_commit_q == rd_ptr_q));

  always_comb begin
    s_ready = 1'b0;
    if (!tx_rst) begin
      if (FRAME_FIFO && DROP_WHEN_FULL) begin
        s_ready = 1'b1;
      end else begin
        s_ready = (wr_state_q == ST_DROP) || !full || hit_full;
      end
    end
  end

  assign s_axis.tready = s_ready;
  assign s_accept      = s_axis.tvalid && s_ready;
  assign drop_beat     = (wr_state_q == ST_DROP) || hit_full;
  assign mem_we        = s_accept && !drop_beat;
  assign in_word       = {s_axis.tlast, s_axis.tuser, s_axis.tkeep, s_axis.tdata};

  // Write side: frame FSM, write/commit pointers and status pulses.
  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      wr_ptr_cur_q    <= '0;
      wr_ptr_commit_q <= '0;
      wr_state_q      <= ST_IDLE;
      overflow_q      <= 1'b0;
      bad_frame_q     <= 1'b0;
      good_frame_q    <= 1'b0;
    end else begin
      overflow_q   <= 1'b0;
      bad_frame_q  <= 1'b0;
      good_frame_q <= 1'b0;
      if (s_accept) begin
        if (drop_beat) begin
          // Discard everything written for this frame; keep swallowing beats
          // until its tlast so the next frame starts cleanly.
          wr_ptr_cur_q <= wr_ptr_commit_q;
          if (s_axis.tlast) begin
            wr_state_q <= ST_IDLE;
            overflow_q <= 1'b1;
          end else begin
            wr_state_q <= ST_DROP;
          end
        end else begin
          wr_ptr_cur_q <= wr_ptr_cur_q + PTR_ONE;
          if (!FRAME_FIFO) begin
            wr_ptr_commit_q <= wr_ptr_cur_q + PTR_ONE;
          end
          if (s_axis.tlast) begin
            wr_state_q <= ST_IDLE;
            if (FRAME_FIFO && DROP_BAD_FRAME && s_axis.tuser[0]) begin
              wr_ptr_cur_q <= wr_ptr_commit_q;
              bad_frame_q  <= 1'b1;
            end else begin
              wr_ptr_commit_q <= wr_ptr_cur_q + PTR_ONE;
              good_frame_q    <= 1'b1;
            end
          end else begin
            wr_state_q <= ST_WRITE;
          end
        end
      end
    end
  end

  always_ff @(posedge tx_clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_cur_q[ADDR_W-1:0]] <= in_word;
    end
  end

  // Read side: single output register refilled whenever it is free or being
  // consumed, so back-to-back words stream at full rate.
  assign m_load = (!m_tvalid_q || m_axis.tready) && !empty;

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      rd_ptr_q   <= '0;
      m_tvalid_q <= 1'b0;
    end else if (m_load) begin
      rd_ptr_q   <= rd_ptr_q + PTR_ONE;
      m_tvalid_q <= 1'b1;
    end else if (m_axis.tready) begin
      m_tvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge tx_clk) begin
    if (m_load) begin
      m_word_q <= mem_q[rd_ptr_q[ADDR_W-1:0]];
    end
  end

  assign m_axis.tdata  = m_word_q[DATA_W-1:0];
  assign m_axis.tkeep  = m_word_q[DATA_W +: KEEP_W];
  assign m_axis.tuser  = m_word_q[DATA_W+KEEP_W +: USER_W];
  assign m_axis.tlast  = m_word_q[WORD_W-1];
  assign m_axis.tvalid = m_tvalid_q;

  assign status_depth      = wr_ptr_cur_q - rd_ptr_q;
  assign status_overflow   = overflow_q;
  assign status_bad_frame  = bad_frame_q;
  assign status_good_frame = good_frame_q;

endmodule

// File: tb/tb_taxi_axis_frame_fifo.sv
// ---------------------------------------------------------------------------
// tb_taxi_axis_frame_fifo
//   Four FIFO instances cover the configurations of interest:
//     u0: word cut-through, DEPTH 16     u1: frame mode, DEPTH 16
//     u2: word cut-through, DEPTH 4      u3: frame mode, DEPTH 4
//   A shared driver feeds the instance chosen by sel; a scoreboard queue
//   holds the beats expected at the selected output.
// ---------------------------------------------------------------------------
module tb_taxi_axis_frame_fifo;

  logic tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  logic        tx_rst;
  int          sel;
  logic [63:0] d_data;
  logic [7:0]  d_keep;
  logic [1:0]  d_user;
  logic        d_last;
  logic        d_valid;
  logic        d_mready;

  int checks = 0;
  int errors = 0;
  int ovf_cnt = 0;

  logic [74:0] sb[$];

  typedef struct {
    int          dut;
    logic [63:0] data;
    logic [7:0]  keep;
    logic [1:0]  user;
    logic        last;
    bit          out;
    bit          chk;
    bit          vld;
    int          depth;
    bit          good;
    bit          bad;
    bit          ovf;
    int          gap;
  } vec_t;

  taxi_axis_frame_fifo_if #(.DATA_W(64), .KEEP_W(8), .USER_W(2)) s0 ();
  taxi_axis_frame_fifo_if #(.DATA_W(64), .KEEP_W(8), .USER_W(2)) m0 ();
  taxi_axis_frame_fifo_if #(.DATA_W(64), .KEEP_W(8), .USER_W(2)) s1 ();
  taxi_axis_frame_fifo_if #(.DATA_W(64), .KEEP_W(8), .USER_W(2)) m1 ();
  taxi_axis_frame_fifo_if #(.DATA_W(64), .KEEP_W(8), .USER_W(2)) s2 ();
  taxi_axis_frame_fifo_if #(.DATA_W(64), .KEEP_W(8), .USER_W(2)) m2 ();
  taxi_axis_frame_fifo_if #(.DATA_W(64), .KEEP_W(8), .USER_W(2)) s3 ();
  taxi_axis_frame_fifo_if #(.DATA_W(64), .KEEP_W(8), .USER_W(2)) m3 ();

  assign s0.tdata = d_data; assign s0.tkeep = d_keep; assign s0.tuser = d_user;
  assign s0.tlast = d_last; assign s0.tvalid = d_valid && (sel == 0); assign m0.tready = d_mready;
  assign s1.tdata = d_data; assign s1.tkeep = d_keep; assign s1.tuser = d_user;
  assign s1.tlast = d_last; assign s1.tvalid = d_valid && (sel == 1); assign m1.tready = d_mready;
  assign s2.tdata = d_data; assign s2.tkeep = d_keep; assign s2.tuser = d_user;
  assign s2.tlast = d_last; assign s2.tvalid = d_valid && (sel == 2); assign m2.tready = d_mready;
  assign s3.tdata = d_data; assign s3.tkeep = d_keep; assign s3.tuser = d_user;
  assign s3.tlast = d_last; assign s3.tvalid = d_valid && (sel == 3); assign m3.tready = d_mready;

  logic [4:0] dep0, dep1;
  logic [2:0] dep2, dep3;
  logic ovf0, bad0, good0, ovf1, bad1, good1, ovf2, bad2, good2, ovf3, bad3, good3;

  taxi_axis_frame_fifo #(.DATA_W(64), .KEEP_W(8), .USER_W(2), .DEPTH(16),
    .FRAME_FIFO(1'b0), .DROP_BAD_FRAME(1'b1), .DROP_WHEN_FULL(1'b0)) u0 (
    .tx_clk(tx_clk), .tx_rst(tx_rst), .s_axis(s0), .m_axis(m0), .status_depth(dep0),
    .status_overflow(ovf0), .status_bad_frame(bad0), .status_good_frame(good0));
  taxi_axis_frame_fifo #(.DATA_W(64), .KEEP_W(8), .USER_W(2), .DEPTH(16),
    .FRAME_FIFO(1'b1), .DROP_BAD_FRAME(1'b1), .DROP_WHEN_FULL(1'b0)) u1 (
    .tx_clk(tx_clk), .tx_rst(tx_rst), .s_axis(s1), .m_axis(m1), .status_depth(dep1),
    .status_overflow(ovf1), .status_bad_frame(bad1), .status_good_frame(good1));
  taxi_axis_frame_fifo #(.DATA_W(64), .KEEP_W(8), .USER_W(2), .DEPTH(4),
    .FRAME_FIFO(1'b0), .DROP_BAD_FRAME(1'b1), .DROP_WHEN_FULL(1'b0)) u2 (
    .tx_clk(tx_clk), .tx_rst(tx_rst), .s_axis(s2), .m_axis(m2), .status_depth(dep2),
    .status_overflow(ovf2), .status_bad_frame(bad2), .status_good_frame(good2));
  taxi_axis_frame_fifo #(.DATA_W(64), .KEEP_W(8), .USER_W(2), .DEPTH(4),
    .FRAME_FIFO(1'b1), .DROP_BAD_FRAME(1'b1), .DROP_WHEN_FULL(1'b0)) u3 (
    .tx_clk(tx_clk), .tx_rst(tx_rst), .s_axis(s3), .m_axis(m3), .status_depth(dep3),
    .status_overflow(ovf3), .status_bad_frame(bad3), .status_good_frame(good3));

  logic [63:0] o_data;
  logic [7:0]  o_keep;
  logic [1:0]  o_user;
  logic        o_last, o_valid, o_sready, o_ovf, o_bad, o_good;
  int          o_depth;

  always_comb begin
    o_data = m0.tdata; o_keep = m0.tkeep; o_user = m0.tuser; o_last = m0.tlast;
    o_valid = m0.tvalid; o_sready = s0.tready; o_depth = int'(dep0);
    o_ovf = ovf0; o_bad = bad0; o_good = good0;
    case (sel)
      1: begin
        o_data = m1.tdata; o_keep = m1.tkeep; o_user = m1.tuser; o_last = m1.tlast;
        o_valid = m1.tvalid; o_sready = s1.tready; o_depth = int'(dep1);
        o_ovf = ovf1; o_bad = bad1; o_good = good1;
      end
      2: begin
        o_data = m2.tdata; o_keep = m2.tkeep; o_user = m2.tuser; o_last = m2.tlast;
        o_valid = m2.tvalid; o_sready = s2.tready; o_depth = int'(dep2);
        o_ovf = ovf2; o_bad = bad2; o_good = good2;
      end
      3: begin
        o_data = m3.tdata; o_keep = m3.tkeep; o_user = m3.tuser; o_last = m3.tlast;
        o_valid = m3.tvalid; o_sready = s3.tready; o_depth = int'(dep3);
        o_ovf = ovf3; o_bad = bad3; o_good = good3;
      end
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: a beat transfers at the next rising edge when valid and
  // ready are both high at the falling edge.
  always @(negedge tx_clk) begin
    if (!tx_rst) begin
      if (o_valid && d_mready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none", {o_last, o_user, o_keep, o_data});
        end else begin
          check("out_beat", {o_last, o_user, o_keep, o_data}, sb.pop_front());
        end
      end
      if (o_ovf) ovf_cnt++;
    end
  end

  function automatic vec_t mkv(int dut, logic [63:0] data, logic [7:0] keep, logic [1:0] user,
                               logic last, bit out, bit vld, int depth, bit good, bit bad,
                               bit ovf, int gap);
    vec_t v;
    v.dut = dut; v.data = data; v.keep = keep; v.user = user; v.last = last; v.out = out;
    v.chk = 1'b1; v.vld = vld; v.depth = depth; v.good = good; v.bad = bad; v.ovf = ovf;
    v.gap = gap;
    return v;
  endfunction

  task automatic idle(input int n);
    d_valid = 1'b0;
    repeat (n) @(posedge tx_clk);
    #1;
  endtask

  task automatic wait_drain();
    d_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !o_valid) break;
      @(posedge tx_clk);
      #1;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  // Drive one beat, wait (bounded) for acceptance, then check the state seen
  // just after the accepting edge. tvalid is left high for back-to-back use.
  task automatic send(input vec_t v, input string tag);
    bit ok;
    ok = 1'b0;
    sel = v.dut; d_data = v.data; d_keep = v.keep; d_user = v.user; d_last = v.last;
    d_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge tx_clk);
      if (o_sready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: got tready=0 expected tready=1 within 40 cycles", tag);
      d_valid = 1'b0;
      return;
    end
    @(posedge tx_clk);
    #1;
    if (v.out) sb.push_back({v.last, v.user, v.keep, v.data});
    if (v.chk) begin
      check({tag, "_vld"}, o_valid, v.vld);
      check({tag, "_depth"}, o_depth, v.depth);
      if (v.last) check({tag, "_pulses"}, {o_ovf, o_bad, o_good}, {v.ovf, v.bad, v.good});
    end
  endtask

  vec_t tbl[$];
  vec_t hv;
  int   n;
  int   ovf_base;

  initial begin
    // Vectors: dut, data, keep, user, last, out, vld, depth, good, bad, ovf, gap
    tbl.push_back(mkv(0, 64'h1111_1111_1111_1111, 8'hFF, 2'b00, 1'b0, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 64'h2222_2222_2222_2222, 8'hFF, 2'b00, 1'b0, 1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 64'h3333_3333_3333_3333, 8'h3F, 2'b01, 1'b1, 1, 1, 1, 1, 0, 0, 3));
    tbl.push_back(mkv(1, 64'hB000_0000_0000_00B0, 8'hFF, 2'b00, 1'b0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 64'hB111_1111_1111_11B1, 8'hFF, 2'b00, 1'b0, 0, 0, 2, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 64'hB222_2222_2222_22B2, 8'h07, 2'b01, 1'b1, 0, 0, 0, 0, 1, 0, 2));
    tbl.push_back(mkv(1, 64'hC0C0_C0C0_C0C0_C0C0, 8'h01, 2'b10, 1'b1, 1, 0, 1, 1, 0, 0, 2));

    tx_rst = 1'b1; sel = 0; d_valid = 1'b0; d_mready = 1'b1;
    d_data = '0; d_keep = '0; d_user = '0; d_last = 1'b0;
    repeat (2) @(posedge tx_clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      sel = k;
      #1;
      check($sformatf("rst%0d_tvalid", k), o_valid, 1'b0);
      check($sformatf("rst%0d_tready", k), o_sready, 1'b0);
      check($sformatf("rst%0d_depth", k), o_depth, 0);
      check($sformatf("rst%0d_pulses", k), {o_ovf, o_bad, o_good}, 3'b000);
    end
    tx_rst = 1'b0;
    sel = 0;
    @(posedge tx_clk);
    #1;

    // Cut-through single beat: visible one cycle after acceptance.
    send(mkv(0, 64'h0123_4567_89AB_CDEF, 8'hFF, 2'b00, 1'b1, 1, 0, 1, 1, 0, 0, 0), "ct1");
    d_valid = 1'b0;
    @(posedge tx_clk);
    #1;
    check("ct1_next_vld", o_valid, 1'b1);
    check("ct1_next_data", o_data, 64'h0123_4567_89AB_CDEF);
    check("ct1_good_once", o_good, 1'b0);
    idle(3);

    for (int i = 0; i < tbl.size(); i++) begin
      send(tbl[i], $sformatf("row%0d", i));
      if (tbl[i].gap > 0) idle(tbl[i].gap);
      if (i == tbl.size() - 1 || tbl[i+1].dut != tbl[i].dut) wait_drain();
    end

    // Frame mode: nothing leaves before tlast, then 4 beats back-to-back.
    d_mready = 1'b1;
    send(mkv(1, 64'hA000_0000_0000_000A, 8'hFF, 2'b00, 1'b0, 1, 0, 1, 0, 0, 0, 0), "ff_b0");
    send(mkv(1, 64'hA111_1111_1111_111A, 8'hFF, 2'b00, 1'b0, 1, 0, 2, 0, 0, 0, 0), "ff_b1");
    send(mkv(1, 64'hA222_2222_2222_222A, 8'hFF, 2'b00, 1'b0, 1, 0, 3, 0, 0, 0, 0), "ff_b2");
    send(mkv(1, 64'hA333_3333_3333_333A, 8'h0F, 2'b00, 1'b1, 1, 0, 4, 1, 0, 0, 0), "ff_b3");
    d_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge tx_clk);
      #1;
      check($sformatf("ff_out%0d_vld", k), o_valid, 1'b1);
      check($sformatf("ff_out%0d_last", k), o_last, (k == 3));
    end
    @(posedge tx_clk);
    #1;
    check("ff_after_vld", o_valid, 1'b0);
    wait_drain();

    // DEPTH 4 cut-through backpressure: RAM fills with 4 words behind the
    // stalled output register, which keeps the first beat.
    sel = 2;
    d_mready = 1'b0;
    n = 0;
    for (int c = 0; c < 20 && n < 6; c++) begin
      d_data = 64'hD000_0000_0000_0000 + 64'(n);
      d_keep = 8'hFF; d_user = 2'b00; d_last = (n == 5); d_valid = 1'b1;
      @(negedge tx_clk);
      if (!o_sready) break;
      @(posedge tx_clk);
      #1;
      sb.push_back({(n == 5), 2'b00, 8'hFF, 64'hD000_0000_0000_0000 + 64'(n)});
      n++;
    end
    check("bp_accepted", n, 5);
    check("bp_tready", o_sready, 1'b0);
    check("bp_depth", o_depth, 4);
    check("bp_vld", o_valid, 1'b1);
    check("bp_data", o_data, 64'hD000_0000_0000_0000);
    repeat (3) @(posedge tx_clk);
    #1;
    check("bp_stall_data", o_data, 64'hD000_0000_0000_0000);
    check("bp_stall_tready", o_sready, 1'b0);
    d_mready = 1'b1;
    hv = mkv(2, 64'hD000_0000_0000_0005, 8'hFF, 2'b00, 1'b1, 1, 0, 0, 0, 0, 0, 0);
    hv.chk = 1'b0;
    send(hv, "bp_b5");
    wait_drain();
    check("bp_depth_end", o_depth, 0);

    // DEPTH 4 frame mode: 6-beat frame cannot fit, is dropped, next frame ok.
    ovf_base = ovf_cnt;
    for (int k = 0; k < 6; k++) begin
      send(mkv(3, 64'hE000_0000_0000_0000 + 64'(k), 8'hFF, 2'b00, (k == 5), 0, 0,
               (k < 4) ? k + 1 : 0, 0, 0, 1, 0), $sformatf("os_b%0d", k));
    end
    d_valid = 1'b0;
    @(posedge tx_clk);
    #1;
    check("os_ovf_once", o_ovf, 1'b0);
    send(mkv(3, 64'hF000_0000_0000_00F0, 8'hFF, 2'b00, 1'b0, 1, 0, 1, 0, 0, 0, 0), "os_f0");
    send(mkv(3, 64'hF111_1111_1111_11F1, 8'h03, 2'b00, 1'b1, 1, 0, 2, 1, 0, 0, 0), "os_f1");
    wait_drain();
    check("os_ovf_count", ovf_cnt - ovf_base, 1);

    // Reset in the middle of a frame while the output holds a valid beat.
    d_mready = 1'b0;
    send(mkv(1, 64'h6000_0000_0000_0006, 8'hFF, 2'b00, 1'b0, 1, 0, 1, 0, 0, 0, 0), "mr_g0");
    send(mkv(1, 64'h6111_1111_1111_1116, 8'hFF, 2'b00, 1'b1, 1, 0, 2, 1, 0, 0, 0), "mr_g1");
    d_valid = 1'b0;
    @(posedge tx_clk);
    #1;
    check("mr_pre_vld", o_valid, 1'b1);
    hv = mkv(1, 64'h7000_0000_0000_0007, 8'hFF, 2'b00, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    hv.chk = 1'b0;
    send(hv, "mr_h0");
    #2;
    tx_rst = 1'b1;
    #1;
    check("mr_rst_vld", o_valid, 1'b0);
    check("mr_rst_depth", o_depth, 0);
    check("mr_rst_tready", o_sready, 1'b0);
    sb.delete();
    d_valid = 1'b0;
    repeat (2) @(posedge tx_clk);
    #1;
    tx_rst = 1'b0;
    @(posedge tx_clk);
    #1;
    d_mready = 1'b1;
    send(mkv(1, 64'h8000_0000_0000_0008, 8'hFF, 2'b00, 1'b0, 1, 0, 1, 0, 0, 0, 0), "mr_k0");
    send(mkv(1, 64'h8111_1111_1111_1118, 8'h7F, 2'b10, 1'b1, 1, 0, 2, 1, 0, 0, 0), "mr_k1");
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
